// File: rtl/block_li_interp.sv
// Dual-channel linear interpolator: raises the L+R / L-R sample rate by 2**LOG2_UP
// by stepping an accumulator from the previous input towards the newest one.
module block_li_interp #(
    parameter int N       = 18,
    parameter int LOG2_UP = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en_in,
    input  logic         en_out,
    input  logic [N-1:0] LI_in_LpR,
    input  logic [N-1:0] LI_in_LmR,
    output logic [N-1:0] LpR_out,
    output logic [N-1:0] LmR_out,
    output logic         out_valid,
    output logic         underrun
);

    localparam int NCH = 2;
    localparam int DW  = N + 1;
    localparam int AW  = N + LOG2_UP + 1;
    localparam int KW  = LOG2_UP + 1;
    localparam logic [KW-1:0] K_FULL = KW'(1 << LOG2_UP);

    // ------------------------------------------------------------------
    // Shared control path: segment counter, output strobe, sticky error
    // ------------------------------------------------------------------
    logic [KW-1:0] k_q, k_d;
    logic          valid_q, valid_d;
    logic          underrun_q, underrun_d;
    logic          seg_live;
    logic          step_acc;

    // k never exceeds L, so "not full" is the same as k < L
    assign seg_live = (k_q != K_FULL);
    assign step_acc = en_out && !en_in && seg_live;

    always_comb begin
        k_d        = k_q;
        valid_d    = en_out;
        underrun_d = underrun_q;
        if (en_in) begin
            k_d = en_out ? KW'(1) : KW'(0);
        end else if (en_out) begin
            if (seg_live) begin
                k_d = k_q + KW'(1);
            end else begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            k_q        <= K_FULL;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            k_q        <= k_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
        end
    end

    assign out_valid = valid_q;
    assign underrun  = underrun_q;

    // ------------------------------------------------------------------
    // Per-channel datapath, both channels driven by the same strobes
    // ------------------------------------------------------------------
    logic [NCH-1:0][N-1:0] din_w;
    logic [NCH-1:0][N-1:0] dout_w;

    assign din_w = {LI_in_LmR, LI_in_LpR};

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [N-1:0]  x1_q, x1_d;
            logic [DW-1:0] delta_q, delta_d;
            logic [AW-1:0] acc_q, acc_d;
            logic [N-1:0]  out_q, out_d;

            logic [DW-1:0] delta_new;
            logic [AW-1:0] x1_shift;
            logic [AW-1:0] delta_new_wide;
            logic [AW-1:0] delta_q_wide;

            assign delta_new      = {din_w[gi][N-1], din_w[gi]} - {x1_q[N-1], x1_q};
            assign x1_shift       = {{(AW-N-LOG2_UP){x1_q[N-1]}}, x1_q, {LOG2_UP{1'b0}}};
            assign delta_new_wide = {{(AW-DW){delta_new[DW-1]}}, delta_new};
            assign delta_q_wide   = {{(AW-DW){delta_q[DW-1]}}, delta_q};

            always_comb begin
                x1_d    = x1_q;
                delta_d = delta_q;
                acc_d   = acc_q;
                out_d   = out_q;
                if (en_in) begin
                    x1_d    = din_w[gi];
                    delta_d = delta_new;
                    if (en_out) begin
                        // j=0 of the new segment is emitted in the load cycle itself
                        out_d = x1_q;
                        acc_d = x1_shift + delta_new_wide;
                    end else begin
                        acc_d = x1_shift;
                    end
                end else if (step_acc) begin
                    // Dropping the low LOG2_UP bits of a two's complement value is a floor
                    out_d = acc_q[N+LOG2_UP-1:LOG2_UP];
                    acc_d = acc_q + delta_q_wide;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    x1_q    <= '0;
                    delta_q <= '0;
                    acc_q   <= '0;
                    out_q   <= '0;
                end else begin
                    x1_q    <= x1_d;
                    delta_q <= delta_d;
                    acc_q   <= acc_d;
                    out_q   <= out_d;
                end
            end

            assign dout_w[gi] = out_q;
        end
    endgenerate

    assign LpR_out = dout_w[0];
    assign LmR_out = dout_w[1];

endmodule
